// File: rtl/fizz_buzz_pkg.sv
// Shared types and helpers for the Fizz Buzz checker and its expected-sequence
// generator: result selector encodings, the checker state type, and the
// selector derivation from the mod-3 / mod-5 zero flags.
package fizz_buzz_pkg;

  localparam logic [2:0] SEL_NUM      = 3'b000;
  localparam logic [2:0] SEL_FIZZ     = 3'b001;
  localparam logic [2:0] SEL_BUZZ     = 3'b010;
  localparam logic [2:0] SEL_FIZZBUZZ = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RECV = 2'd2,
    ST_FIN  = 2'd3
  } fb_state_e;

  // FizzBuzz takes priority over Buzz, which takes priority over Fizz.
  function automatic logic [2:0] sel_of(input logic m3_zero, input logic m5_zero);
    if (m3_zero && m5_zero) return SEL_FIZZBUZZ;
    if (m5_zero)            return SEL_BUZZ;
    if (m3_zero)            return SEL_FIZZ;
    return SEL_NUM;
  endfunction

endpackage

// File: rtl/fizz_buzz_expect.sv
// Expected-sequence generator: walks idx = 1, 2, 3, ... and the matching
// Fizz/Buzz selector using wrapping mod-3 / mod-5 counters (no divider).
//   CLK, RESET_n : clock, async active-low reset (counters clear to 0)
//   init         : load idx=1, m3=1, m5=1
//   adv          : step to the next index (ignored while init is high)
//   idx, sel     : current expected number and selector
module fizz_buzz_expect
  import fizz_buzz_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        init,
  input  logic        adv,
  output logic [31:0] idx,
  output logic [2:0]  sel
);

  logic [1:0] m3;
  logic [2:0] m5;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      idx <= '0;
      m3  <= '0;
      m5  <= '0;
    end else if (init) begin
      idx <= 32'd1;
      m3  <= 2'd1;
      m5  <= 3'd1;
    end else if (adv) begin
      idx <= idx + 32'd1;
      m3  <= (m3 == 2'd2) ? 2'd0 : m3 + 2'd1;
      m5  <= (m5 == 3'd4) ? 3'd0 : m5 + 3'd1;
    end
  end

  assign sel = sel_of(m3 == 2'd0, m5 == 3'd0);

endmodule

// File: rtl/fizz_buzz_checker.sv
// Self-checking initiator/receiver for the Fizz Buzz generator. Issues one
// max-count request, then checks every returned word against 1..N.
//   START/MAX_COUNT      : run trigger and count N (sampled in IDLE)
//   REQ_VALID/READY/DATA : request handshake carrying N
//   RSP_VALID/DATA/FIZZBUZZ : result stream from the generator
//   BUSY, DONE, PASS, TIMEOUT, ERR_COUNT, FIRST_ERR_INDEX : run status
module fizz_buzz_checker
  import fizz_buzz_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC       = 1024,
  parameter bit          CHECK_DATA_ALWAYS = 1'b0
) (
  input  logic        RESET_n,
  input  logic        CLK,
  input  logic        START,
  input  logic [31:0] MAX_COUNT,
  input  logic        REQ_READY,
  output logic        REQ_VALID,
  output logic [31:0] REQ_DATA,
  input  logic        RSP_VALID,
  input  logic [31:0] RSP_DATA,
  input  logic [2:0]  RSP_FIZZBUZZ,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic        TIMEOUT,
  output logic [31:0] ERR_COUNT,
  output logic [31:0] FIRST_ERR_INDEX
);

  fb_state_e   state_q, state_d;
  logic [31:0] n_q, wd_q, err_q, ferr_q;
  logic        req_vld_q, tmo_q, pass_q;
  logic [31:0] exp_idx;
  logic [2:0]  exp_sel;
  logic        start_go, req_xfer, rsp_acc, mism, wd_hit, active;

  assign active   = (state_q == ST_REQ) || (state_q == ST_RECV);
  assign start_go = (state_q == ST_IDLE) && START;
  assign req_xfer = (state_q == ST_REQ) && req_vld_q && REQ_READY;
  assign rsp_acc  = (state_q == ST_RECV) && RSP_VALID;

  // Data is only meaningful on plain-number words unless always checked.
  assign mism = (RSP_FIZZBUZZ != exp_sel) ||
                ((CHECK_DATA_ALWAYS || exp_sel == SEL_NUM) && (RSP_DATA != exp_idx));

  // A transfer or accepted word in the same cycle beats the watchdog.
  assign wd_hit = (TIMEOUT_CYC != 0) && active && !req_xfer && !rsp_acc &&
                  (wd_q == 32'(TIMEOUT_CYC - 1));

  fizz_buzz_expect u_exp (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .init    (start_go),
    .adv     (rsp_acc),
    .idx     (exp_idx),
    .sel     (exp_sel)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (START) state_d = (MAX_COUNT == 32'd0) ? ST_FIN : ST_REQ;
      ST_REQ:  if (req_xfer) state_d = ST_RECV;
               else if (wd_hit) state_d = ST_FIN;
      ST_RECV: if (rsp_acc && exp_idx == n_q) state_d = ST_FIN;
               else if (wd_hit) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      wd_q      <= '0;
      err_q     <= '0;
      ferr_q    <= '0;
      req_vld_q <= 1'b0;
      tmo_q     <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_go) begin
        n_q       <= MAX_COUNT;
        err_q     <= '0;
        ferr_q    <= '0;
        tmo_q     <= 1'b0;
        pass_q    <= 1'b0;
        req_vld_q <= (MAX_COUNT != 32'd0);
      end
      if (req_xfer) req_vld_q <= 1'b0;
      if ((state_d != state_q) || req_xfer || rsp_acc) wd_q <= '0;
      else if (active) wd_q <= wd_q + 32'd1;
      if (wd_hit) tmo_q <= 1'b1;
      if (rsp_acc && mism) begin
        if (err_q != 32'hFFFF_FFFF) err_q <= err_q + 32'd1;
        if (err_q == 32'd0) ferr_q <= exp_idx;
      end
      if (state_q == ST_FIN) pass_q <= (err_q == 32'd0) && !tmo_q;
    end
  end

  // PASS is formed from registered status so it is already valid in FIN.
  assign PASS            = pass_q | ((state_q == ST_FIN) && (err_q == 32'd0) && !tmo_q);
  assign DONE            = (state_q == ST_FIN);
  assign BUSY            = active;
  assign REQ_VALID       = req_vld_q;
  assign REQ_DATA        = n_q;
  assign TIMEOUT         = tmo_q;
  assign ERR_COUNT       = err_q;
  assign FIRST_ERR_INDEX = ferr_q;

endmodule

// File: tb/tb_fizz_buzz_checker.sv
module tb_fizz_buzz_checker;

  typedef struct {
    logic [31:0] err;
    logic [31:0] ferr;
    logic        pass;
    logic        tmo;
  } res_t;

  logic        CLK, RESET_n, START, REQ_READY, REQ_VALID, RSP_VALID;
  logic        BUSY, DONE, PASS, TIMEOUT;
  logic [31:0] MAX_COUNT, REQ_DATA, RSP_DATA, ERR_COUNT, FIRST_ERR_INDEX;
  logic [2:0]  RSP_FIZZBUZZ;

  int n_chk = 0;
  int n_fail = 0;
  res_t exp_q[$];
  logic [2:0] force_sel[int];
  logic [31:0] force_data[int];

  fizz_buzz_checker #(.TIMEOUT_CYC(16), .CHECK_DATA_ALWAYS(1'b0)) dut (
    .RESET_n(RESET_n), .CLK(CLK), .START(START), .MAX_COUNT(MAX_COUNT),
    .REQ_READY(REQ_READY), .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_FIZZBUZZ(RSP_FIZZBUZZ),
    .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .TIMEOUT(TIMEOUT),
    .ERR_COUNT(ERR_COUNT), .FIRST_ERR_INDEX(FIRST_ERR_INDEX)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] gsel(input int i);
    if (i % 15 == 0) return 3'b100;
    if (i % 5 == 0)  return 3'b010;
    if (i % 3 == 0)  return 3'b001;
    return 3'b000;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard pop: every DONE pulse retires one expected run result.
  always @(negedge CLK) begin
    if (RESET_n && DONE) begin
      if (exp_q.size() == 0) chk("sb_nonempty", 32'(exp_q.size()), 32'd1);
      else begin
        res_t e;
        e = exp_q.pop_front();
        chk("err_count", ERR_COUNT, e.err);
        chk("first_err", FIRST_ERR_INDEX, e.ferr);
        chk("pass", {31'd0, PASS}, {31'd0, e.pass});
        chk("timeout", {31'd0, TIMEOUT}, {31'd0, e.tmo});
      end
    end
  end

  // One run: request handshake, then words 1..stop_at from a generator model
  // (with optional forced corruptions), then wait for DONE unless aborting.
  task automatic run(input int n, input int stop_at, input int gmax, input int rdy_dly,
                     input bit abort, input res_t e);
    int k;
    if (!abort) exp_q.push_back(e);
    MAX_COUNT = n; START = 1'b1;
    tick();
    START = 1'b0; MAX_COUNT = $urandom;
    if (n != 0) begin
      chk("req_valid", {31'd0, REQ_VALID}, 32'd1);
      chk("req_data", REQ_DATA, n);
      chk("busy", {31'd0, BUSY}, 32'd1);
      for (int i = 0; i < rdy_dly; i++) begin
        tick();
        chk("req_hold", {31'd0, REQ_VALID}, 32'd1);
        chk("req_stable", REQ_DATA, n);
      end
      REQ_READY = 1'b1;
      tick();
      REQ_READY = 1'b0;
      chk("req_drop", {31'd0, REQ_VALID}, 32'd0);
      for (int i = 1; i <= stop_at; i++) begin
        repeat ($urandom_range(gmax, 0)) tick();
        RSP_VALID = 1'b1;
        RSP_DATA = force_data.exists(i) ? force_data[i] : 32'(i);
        RSP_FIZZBUZZ = force_sel.exists(i) ? force_sel[i] : gsel(i);
        tick();
        RSP_VALID = 1'b0;
        RSP_DATA = '0;
        RSP_FIZZBUZZ = 3'b111;
      end
    end else begin
      chk("no_req_n0", {31'd0, REQ_VALID}, 32'd0);
    end
    if (abort) return;
    k = 0;
    while (!DONE && k < 40) begin
      tick();
      k++;
    end
    chk("done_seen", {31'd0, DONE}, 32'd1);
    if (n == 0) chk("done_lat_n0", {31'd0, k <= 1}, 32'd1);
    else chk("done_lat", k, (stop_at < n) ? 16 : 0);
    tick();
    chk("done_pulse", {31'd0, DONE}, 32'd0);
    chk("pass_held", {31'd0, PASS}, {31'd0, e.pass});
    chk("tmo_held", {31'd0, TIMEOUT}, {31'd0, e.tmo});
    chk("busy_off", {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    res_t good;
    res_t r;
    good = '{err: 0, ferr: 0, pass: 1'b1, tmo: 1'b0};
    RESET_n = 1'b0; START = 1'b0; MAX_COUNT = '0; REQ_READY = 1'b0;
    RSP_VALID = 1'b0; RSP_DATA = '0; RSP_FIZZBUZZ = '0;
    repeat (3) tick();
    chk("rst_outputs", {REQ_VALID, BUSY, DONE, PASS, TIMEOUT}, 32'd0);
    chk("rst_err", ERR_COUNT | FIRST_ERR_INDEX | REQ_DATA, 32'd0);
    RESET_n = 1'b1;
    // Stray responses in IDLE must not count.
    RSP_VALID = 1'b1; RSP_FIZZBUZZ = 3'b111;
    repeat (2) tick();
    RSP_VALID = 1'b0;
    chk("idle_ignore", ERR_COUNT, 32'd0);

    run(15, 15, 0, 0, 1'b0, good);

    force_sel[9] = 3'b000; force_sel[10] = 3'b001;
    r = '{err: 2, ferr: 9, pass: 1'b0, tmo: 1'b0};
    run(15, 15, 0, 0, 1'b0, r);
    force_sel.delete();

    // Data is checked on plain words only: word 7 counts, word 6 (Fizz) does not.
    force_data[7] = 32'd77; force_data[6] = 32'd99;
    r = '{err: 1, ferr: 7, pass: 1'b0, tmo: 1'b0};
    run(15, 15, 1, 0, 1'b0, r);
    force_data.delete();

    run(100, 100, 3, 5, 1'b0, good);
    run(0, 0, 0, 0, 1'b0, good);

    r = '{err: 0, ferr: 0, pass: 1'b0, tmo: 1'b1};
    run(10, 4, 0, 0, 1'b0, r);
    run(10, 10, 2, 1, 1'b0, good);

    force_sel[3] = 3'b000;
    run(100, 50, 1, 0, 1'b1, good);
    force_sel.delete();
    chk("pre_rst_err", ERR_COUNT, 32'd1);
    chk("pre_rst_busy", {31'd0, BUSY}, 32'd1);
    #2 RESET_n = 1'b0;
    #1;
    chk("mid_rst_flags", {REQ_VALID, BUSY, DONE, PASS, TIMEOUT}, 32'd0);
    chk("mid_rst_err", ERR_COUNT | FIRST_ERR_INDEX | REQ_DATA, 32'd0);
    repeat (2) tick();
    RESET_n = 1'b1;
    tick();
    run(20, 20, 2, 2, 1'b0, good);

    repeat (3) tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
